// File: rtl/truth_table_sweeper_pkg.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper_pkg
// Shared definitions for the truth-table sweeper:
//   - sweep_state_e    : controller states
//   - DEFAULT_N_IN     : default number of inputs of the block under sweep
//   - DEFAULT_EXPECTED : canonical truth table of the 5-input merge function,
//                        zero-extended to 64 bits so it can be sliced for any
//                        N_IN in 1..6
//   - LAT_MAX          : largest supported sample latency
//   - is_busy_state()  : decode of the states in which a sweep is in flight
// ----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } sweep_state_e;

  localparam int          DEFAULT_N_IN     = 5;
  localparam logic [63:0] DEFAULT_EXPECTED = 64'h0000_0000_CFC8_9F7F;
  localparam int          LAT_MAX          = 3;
  // Drain counter only has to reach LAT_MAX-1.
  localparam int          DRAIN_CNT_W      = $clog2(LAT_MAX + 1);

  // True while stimulus is being driven or the pipeline is still draining.
  function automatic logic is_busy_state(input sweep_state_e st);
    return (st == SWEEP) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sweep_delay_line.sv
// ----------------------------------------------------------------------------
// sweep_delay_line
// DEPTH-stage register delay used to align {valid, index} with the output of
// the block under sweep. DEPTH = 0 is a combinational pass-through.
// Ports:
//   clk  in  1      rising-edge clock
//   rst  in  1      synchronous active-high reset, clears every stage
//   din  in  WIDTH  value entering the delay line
//   dout out WIDTH  din delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module sweep_delay_line
  import truth_table_sweeper_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int WIDTH = DEFAULT_N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock and reset have no job in the pass-through form.
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = &{1'b0, clk, rst};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift register: stage 0 takes din, each later stage takes its predecessor.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
          end
        end else begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input combination 0..2**N_IN-1 into a combinational (or
// LAT-cycle pipelined) Boolean block, captures the block's output into a
// truth-table signature and compares it against EXPECTED.
// Ports:
//   clk            in  1         rising-edge clock
//   rst            in  1         synchronous active-high reset
//   start          in  1         single-cycle sweep request (IDLE or DONE only)
//   dut_out        in  1         output of the block under sweep
//   vec            out N_IN      stimulus; vec[N_IN-1] is the first input
//   vec_valid      out 1         vec holds a sweep value
//   busy           out 1         sweep or drain in progress
//   done           out 1         one-cycle pulse, results are final
//   pass           out 1         signature matched EXPECTED (held until next start)
//   signature      out 2**N_IN   captured truth table, bit i = output for vector i
//   fail_count     out N_IN+1    number of mismatching entries
//   first_fail_idx out N_IN      lowest mismatching index, 0 if none
// ----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                    N_IN     = DEFAULT_N_IN,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = DEFAULT_EXPECTED[(2**N_IN)-1:0],
  parameter int                    LAT      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dut_out,
  output logic [N_IN-1:0]       vec,
  output logic                  vec_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(2**N_IN)-1:0]  signature,
  output logic [N_IN:0]         fail_count,
  output logic [N_IN-1:0]       first_fail_idx
);

  localparam logic [N_IN-1:0]        VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]        VEC_ONE  = N_IN'(1'b1);
  localparam logic [N_IN:0]          FC_ONE   = (N_IN + 1)'(1'b1);
  localparam logic [DRAIN_CNT_W-1:0] LAT_LAST = DRAIN_CNT_W'((LAT > 0) ? (LAT - 1) : 0);
  localparam logic [DRAIN_CNT_W-1:0] CNT_ONE  = DRAIN_CNT_W'(1'b1);

  // Controller
  sweep_state_e state_r;
  sweep_state_e state_next_s;
  logic         start_accept_s;
  logic         sweep_last_s;
  logic         drain_last_s;
  logic [DRAIN_CNT_W-1:0] drain_cnt_r;

  // Stimulus and status registers
  logic [N_IN-1:0]       vec_r;
  logic                  vec_valid_r;
  logic                  busy_r;
  logic                  done_r;

  // Capture path
  logic [N_IN:0]         dly_in_s;
  logic [N_IN:0]         dly_out_s;
  logic                  samp_valid_s;
  logic [N_IN-1:0]       samp_idx_s;
  logic                  mismatch_s;
  logic [N_IN:0]         fail_count_next_s;

  // Results
  logic                  pass_r;
  logic [(2**N_IN)-1:0]  signature_r;
  logic [N_IN:0]         fail_count_r;
  logic [N_IN-1:0]       first_fail_idx_r;

  assign sweep_last_s = (vec_r == VEC_LAST);
  assign drain_last_s = (drain_cnt_r == LAT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next_s   = state_r;
    start_accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s   = SWEEP;
          start_accept_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SWEEP: begin
        if (sweep_last_s) begin
          if (LAT > 0) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = SWEEP;
        end
      end
      DRAIN: begin
        if (drain_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s   = SWEEP;
          start_accept_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Drain counter: counts cycles spent in DRAIN, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_r <= {DRAIN_CNT_W{1'b0}};
    end else if (state_r == DRAIN) begin
      drain_cnt_r <= drain_cnt_r + CNT_ONE;
    end else begin
      drain_cnt_r <= {DRAIN_CNT_W{1'b0}};
    end
  end

  // Stimulus counter: 0..2**N_IN-1 once, then parks at 0 with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r       <= {N_IN{1'b0}};
      vec_valid_r <= 1'b0;
    end else if (start_accept_s) begin
      vec_r       <= {N_IN{1'b0}};
      vec_valid_r <= 1'b1;
    end else if (state_r == SWEEP) begin
      if (sweep_last_s) begin
        vec_r       <= {N_IN{1'b0}};
        vec_valid_r <= 1'b0;
      end else begin
        vec_r       <= vec_r + VEC_ONE;
        vec_valid_r <= 1'b1;
      end
    end else begin
      vec_r       <= vec_r;
      vec_valid_r <= vec_valid_r;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= is_busy_state(state_next_s);
      done_r <= (state_next_s == DONE);
    end
  end

  // The index travels alongside the block's latency so each sample is
  // written to the entry that produced it.
  assign dly_in_s = {vec_valid_r, vec_r};

  sweep_delay_line #(
    .DEPTH (LAT),
    .WIDTH (N_IN + 1)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in_s),
    .dout (dly_out_s)
  );

  assign samp_valid_s = dly_out_s[N_IN];
  assign samp_idx_s   = dly_out_s[N_IN-1:0];

  // Mismatch detect and the fail count as it will be after this edge; the
  // latter lets pass include the final sample taken on the DONE transition.
  always_comb begin
    mismatch_s        = 1'b0;
    fail_count_next_s = fail_count_r;
    if (samp_valid_s) begin
      mismatch_s        = (dut_out != EXPECTED[samp_idx_s]);
      fail_count_next_s = fail_count_r + {{N_IN{1'b0}}, mismatch_s};
    end else begin
      mismatch_s        = 1'b0;
      fail_count_next_s = fail_count_r;
    end
  end

  // Result capture: cleared on accepted start, updated per valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature_r      <= {(2**N_IN){1'b0}};
      fail_count_r     <= {(N_IN + 1){1'b0}};
      first_fail_idx_r <= {N_IN{1'b0}};
      pass_r           <= 1'b0;
    end else if (start_accept_s) begin
      signature_r      <= {(2**N_IN){1'b0}};
      fail_count_r     <= {(N_IN + 1){1'b0}};
      first_fail_idx_r <= {N_IN{1'b0}};
      pass_r           <= 1'b0;
    end else begin
      if (samp_valid_s) begin
        signature_r[samp_idx_s] <= dut_out;
        if (mismatch_s) begin
          fail_count_r <= fail_count_r + FC_ONE;
          if (fail_count_r == {(N_IN + 1){1'b0}}) begin
            first_fail_idx_r <= samp_idx_s;
          end
        end
      end
      if ((state_next_s == DONE) && (state_r != DONE)) begin
        pass_r <= (fail_count_next_s == {(N_IN + 1){1'b0}});
      end
    end
  end

  assign vec            = vec_r;
  assign vec_valid      = vec_valid_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign signature      = signature_r;
  assign fail_count     = fail_count_r;
  assign first_fail_idx = first_fail_idx_r;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Exhaustive stimulus and capture stage wrapped around an N_IN-input combinational Boolean block (default: the 5-input merge function).
- Upstream role: drives every input combination 0..2**N_IN-1 onto the block's inputs, one per cycle.
- Downstream role: samples the block's output, builds a truth-table signature and compares it against an expected mask.
- Used to check simplified implementations against the canonical sum-of-minterms form, in hardware or in bench.

Parameters:
- N_IN, 5, number of inputs of the block under sweep; legal range 1..6; entries = 2**N_IN.
- EXPECTED, 32'hCFC89F7F, expected truth table; bit i = required output for input vector i (MSB of vector = first input). Width 2**N_IN.
- LAT, 0, cycles between vec changing and the matching dut_out being valid; legal range 0..3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- dut_out  in  1  output of the block under sweep.
- vec  out  N_IN  input vector to the block; vec[N_IN-1] = first input (a), vec[0] = last input (e).
- vec_valid  out  1  vec holds a sweep value.
- busy  out  1  sweep or drain in progress.
- done  out  1  one-cycle pulse: results are final.
- pass  out  1  signature == EXPECTED; valid from done until the next accepted start.
- signature  out  2**N_IN  captured truth table.
- fail_count  out  N_IN+1  number of mismatching entries.
- first_fail_idx  out  N_IN  lowest mismatching index; 0 if none.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high, all state is IDLE and every output is 0.
- Reset mid-sweep: the sweep is aborted with no done pulse. Pipeline valid bits and partial results are cleared.
- FSM states:
  - IDLE: start=1 goes to SWEEP. Results are held.
  - SWEEP: drives vec=0..2**N_IN-1. After the last value, goes to DRAIN if LAT>0, otherwise DONE.
  - DRAIN: waits LAT cycles for the last sample, then goes to DONE.
  - DONE: one cycle, then IDLE.
- Accepted start (IDLE, or DONE for back-to-back runs): at the same edge, clear signature, fail_count and first_fail_idx; clear pass; set vec=0 and vec_valid=1.
- start in SWEEP or DRAIN is ignored.
- Index counter: vec increments by 1 per cycle in SWEEP.
  - Last value: 2**N_IN-1 is driven for exactly one cycle.
  - Next edge: vec_valid falls and vec returns to 0. No wrap-around re-drive.
- Sample pipeline: a LAT-stage shift of {vec_valid, vec}.
  - The sample index is the delayed vec; the sample is taken when the delayed valid is high.
  - At that edge: signature[idx] <= dut_out.
  - On mismatch with EXPECTED[idx]: fail_count increments, and first_fail_idx is set if this is the first mismatch.
- LAT=0: dut_out is sampled in the same cycle vec is driven (combinational block under sweep).
- Timing: if start is sampled at edge E0, the last sample is taken at edge E(2**N_IN + LAT) and done is high in the following cycle.
  - vec_valid is high for exactly 2**N_IN consecutive cycles.
  - done is asserted 2**N_IN + 1 + LAT cycles after the start cycle.
- pass is registered in the DONE transition as (fail_count_final == 0) and held until the next accepted start.
- busy = state in {SWEEP, DRAIN}. busy is 0 in DONE.
- Widths: fail_count is N_IN+1 bits so it holds 2**N_IN without overflow.
- Signature bits for unused positions (when N_IN < 5) are 0.

Decomposition:
- Shared package: state enum {IDLE, SWEEP, DRAIN, DONE}; default N_IN; default EXPECTED mask constant; LAT maximum constant.
- One sub-module: sweep_delay_line. Parameterised depth LAT and width N_IN+1; synchronous reset clears it; LAT=0 is a pass-through.

Test Plan:
- Reset, then start with dut_out from a golden model of 0xCFC89F7F, LAT=0 -> vec 0..31 on consecutive cycles; done 33 cycles after start; pass=1; signature=0xCFC89F7F; fail_count=0; first_fail_idx=0.
- Golden model with bits 19 and 30 inverted -> pass=0; fail_count=2; first_fail_idx=19; signature=0x8FC09F7F.
- LAT=2, block followed by two register stages -> pass=1; done 35 cycles after start; vec_valid high 32 cycles.
- start pulsed at vec=5 and vec=20 during a sweep -> ignored; vec sequence and done timing unchanged.
- rst asserted while vec=10 -> next cycle every output is 0 and no done pulse; a subsequent start gives a full clean sweep with pass=1.
- start asserted in the DONE cycle -> vec=0 and vec_valid=1 the next cycle; results cleared; a second done arrives 33 cycles later.
